// File: rtl/fifo_burst_reader_if.sv
// ----------------------------------------------------------------------------
// fifo_burst_reader_if
//   Bundles the two handshake sides of fifo_burst_reader:
//     - FIFO side (show-head FIFO): NotEmpty, ReadData in; Read out.
//     - Stream side (valid/ready):  Out_Data, Out_Valid, Out_Last out;
//                                   Out_Ready in.
//   Modports:
//     master - the burst reader itself.
//     slave  - the environment: FIFO plus downstream consumer.
// ----------------------------------------------------------------------------
interface fifo_burst_reader_if #(
    parameter int DataWidth = 32
) ();
    // FIFO side
    logic                 NotEmpty;
    logic [DataWidth-1:0] ReadData;
    logic                 Read;

    // Output stream side
    logic [DataWidth-1:0] Out_Data;
    logic                 Out_Valid;
    logic                 Out_Last;
    logic                 Out_Ready;

    modport master (
        input  NotEmpty, ReadData, Out_Ready,
        output Read, Out_Data, Out_Valid, Out_Last
    );

    modport slave (
        output NotEmpty, ReadData, Out_Ready,
        input  Read, Out_Data, Out_Valid, Out_Last
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// ----------------------------------------------------------------------------
// fifo_burst_reader
//   Pops exactly Length words from a show-head FIFO on a Start command and
//   presents them on a valid/ready stream, flagging the final word with
//   Out_Last. A 2-entry skid buffer sits between the FIFO pop and the output
//   so that Read never depends combinationally on Out_Ready, while still
//   sustaining one word per cycle.
//
// Ports:
//   CLK      in   clock
//   Rest     in   synchronous active-high reset
//   Start    in   command pulse, honoured only in IDLE
//   Length   in   burst length in words, sampled on an accepted Start
//   Abort    in   synchronous burst cancel (ignored in IDLE)
//   Busy     out  high in every state except IDLE
//   Done     out  one-cycle pulse on burst completion
//   SentCnt  out  output handshakes in the current / most recent burst
//   bus      -    FIFO and output stream handshakes (fifo_burst_reader_if)
// ----------------------------------------------------------------------------
module fifo_burst_reader #(
    parameter int DataWidth = 32,
    parameter int LenWidth  = 16
) (
    input  logic                 CLK,
    input  logic                 Rest,
    input  logic                 Start,
    input  logic [LenWidth-1:0]  Length,
    input  logic                 Abort,
    output logic                 Busy,
    output logic                 Done,
    output logic [LenWidth-1:0]  SentCnt,
    fifo_burst_reader_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t               state;
    state_t               state_next;

    logic [LenWidth-1:0]  remaining;
    logic [LenWidth-1:0]  sent_cnt;

    // Skid buffer: entry 0 is the oldest word and drives the output.
    logic [DataWidth-1:0] buf_data [2];
    logic                 buf_last [2];
    logic [1:0]           count;

    logic                 rd;
    logic                 hs;
    logic                 abort_hit;
    logic                 start_ok;
    logic                 wr_idx;

    assign bus.Out_Valid = (count != 2'd0);
    assign bus.Out_Data  = buf_data[0];
    assign bus.Out_Last  = buf_last[0];
    assign bus.Read      = rd;

    assign hs        = bus.Out_Valid & bus.Out_Ready;
    assign abort_hit = Abort & (state != IDLE);
    assign start_ok  = (state == IDLE) & Start & ~Abort;

    // When a pop and a push coincide the survivor shifts into entry 0, so the
    // incoming word lands one slot lower than the current count suggests.
    assign wr_idx    = (count == 2'd1) & ~hs;

    assign Busy    = (state != IDLE);
    assign Done    = (state == DONE) & ~Abort;
    assign SentCnt = sent_cnt;

    // ------------------------------------------------------------------------
    // Next-state and FIFO pop decision
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_next = state;
        rd         = 1'b0;

        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_next = (Length != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                // Only registered state plus NotEmpty: no path from Out_Ready.
                rd = bus.NotEmpty & (remaining != '0) & (count != 2'd2);
                if (rd && remaining == LenWidth'(1)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (hs && bus.Out_Last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (abort_hit) begin
            state_next = IDLE;
            rd         = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // State, counters and skid buffer
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register here sees the pre-edge value of every other register.
        if (Rest) begin
            state     <= IDLE;
            count     <= 2'd0;
            remaining <= '0;
            sent_cnt  <= '0;
            // NOTE: the buffer entries are reset because entry 0 drives
            // Out_Data directly, which must read zero out of reset.
            buf_data[0] <= '0;
            buf_data[1] <= '0;
            buf_last[0] <= 1'b0;
            buf_last[1] <= 1'b0;
        end else begin
            state <= state_next;

            if (abort_hit) begin
                count     <= 2'd0;
                remaining <= '0;
            end else begin
                if (start_ok) begin
                    remaining <= Length;
                    sent_cnt  <= '0;
                end else if (rd) begin
                    remaining <= remaining - LenWidth'(1);
                end

                if (hs) begin
                    sent_cnt    <= sent_cnt + LenWidth'(1);
                    buf_data[0] <= buf_data[1];
                    buf_last[0] <= buf_last[1];
                end

                // Written after the shift so a same-cycle push into entry 0
                // overrides the shifted (stale) entry 1.
                if (rd) begin
                    buf_data[wr_idx] <= bus.ReadData;
                    buf_last[wr_idx] <= (remaining == LenWidth'(1));
                end

                count <= count + {1'b0, rd} - {1'b0, hs};
            end
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// ----------------------------------------------------------------------------
// tb_fifo_burst_reader
//   Drives fifo_burst_reader from a queue-based show-head FIFO and a
//   configurable downstream consumer, and compares every cycle against a
//   transaction-level model: a scoreboard of popped words (with the expected
//   last flag), counts of words still to read / still to send, and a pending
//   Done flag.
// ----------------------------------------------------------------------------
module tb_fifo_burst_reader;

    localparam int DW = 32;
    localparam int LW = 16;

    logic          CLK = 1'b0;
    logic          Rest;
    logic          Start;
    logic [LW-1:0] Length;
    logic          Abort;
    logic          Busy;
    logic          Done;
    logic [LW-1:0] SentCnt;

    fifo_burst_reader_if #(.DataWidth(DW)) bus ();

    fifo_burst_reader #(
        .DataWidth(DW),
        .LenWidth (LW)
    ) dut (
        .CLK    (CLK),
        .Rest   (Rest),
        .Start  (Start),
        .Length (Length),
        .Abort  (Abort),
        .Busy   (Busy),
        .Done   (Done),
        .SentCnt(SentCnt),
        .bus    (bus.master)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Environment and reference model
    // ------------------------------------------------------------------------
    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } item_t;

    logic [DW-1:0] fifo_q [$];   // show-head FIFO contents
    item_t         sb     [$];   // words popped but not yet handshaken

    bit            m_active;       // burst running (reads or sends left)
    bit            m_done_pending; // Done expected in the current cycle
    int            m_reads_left;
    int            m_out_left;
    int            m_sent;

    int            ready_mode = 0; // 0 always, 1 pattern 1,0,0, 2 random, 3 never
    int            feed_mode  = 0; // 0 none, 1 one word every 3 cycles, 2 random
    bit            rand_abort = 0;
    int            cyc        = 0;
    logic [DW-1:0] feed_word  = '0;

    bit            prev_stall = 0;
    logic [DW-1:0] prev_data  = '0;

    function automatic bit m_busy();
        return m_active || m_done_pending;
    endfunction

    task automatic model_reset();
        m_active       = 0;
        m_done_pending = 0;
        m_reads_left   = 0;
        m_out_left     = 0;
        m_sent         = 0;
        sb.delete();
        prev_stall     = 0;
    endtask

    // One clock cycle: apply inputs at the negedge, check at negedge+1,
    // advance the model, then move to the next negedge.
    task automatic tick();
        bit    exp_read;
        bit    hs;
        bit    was_busy;
        bit    new_done;
        item_t it;

        case (feed_mode)
            1: if (cyc % 3 == 0) begin
                   fifo_q.push_back(feed_word);
                   feed_word++;
               end
            2: if ($urandom_range(0, 2) != 0 && fifo_q.size() < 16) fifo_q.push_back($urandom());
            default: ;
        endcase

        case (ready_mode)
            0:       bus.Out_Ready = 1'b1;
            1:       bus.Out_Ready = (cyc % 3 == 0);
            2:       bus.Out_Ready = 1'($urandom_range(0, 1));
            default: bus.Out_Ready = 1'b0;
        endcase

        if (rand_abort && m_busy() && $urandom_range(0, 39) == 0) Abort = 1'b1;

        bus.NotEmpty = (fifo_q.size() != 0);
        bus.ReadData = (fifo_q.size() != 0) ? fifo_q[0] : '0;
        #1;

        hs       = bus.Out_Valid && bus.Out_Ready;
        was_busy = m_busy();

        if (!Rest) begin
            exp_read = m_active && (m_reads_left > 0) && (fifo_q.size() != 0) &&
                       (sb.size() < 2) && !Abort;
            check("read",    bus.Read,      exp_read);
            check("valid",   bus.Out_Valid, sb.size() != 0);
            check("busy",    Busy,          was_busy);
            check("done",    Done,          m_done_pending && !Abort);
            check("sentcnt", SentCnt,       m_sent[LW-1:0]);
            if (bus.Out_Valid && sb.size() != 0) begin
                check("data", bus.Out_Data, sb[0].data);
                check("last", bus.Out_Last, sb[0].last);
            end
            if (prev_stall) begin
                check("hold_valid", bus.Out_Valid, 1'b1);
                check("hold_data",  bus.Out_Data,  prev_data);
            end
        end

        if (Rest) begin
            model_reset();
        end else if (was_busy && Abort) begin
            m_active       = 0;
            m_done_pending = 0;
            sb.delete();
            prev_stall     = 0;
        end else begin
            new_done   = 0;
            prev_stall = bus.Out_Valid && !bus.Out_Ready;
            prev_data  = bus.Out_Data;
            if (hs && sb.size() != 0) begin
                void'(sb.pop_front());
                m_sent++;
                m_out_left--;
                if (m_active && m_out_left == 0) begin
                    new_done = 1;
                    m_active = 0;
                end
            end
            if (bus.Read && fifo_q.size() != 0) begin
                it.data = fifo_q[0];
                it.last = (m_reads_left == 1);
                sb.push_back(it);
                m_reads_left--;
            end
            if (!was_busy && Start && !Abort) begin
                if (Length == '0) begin
                    new_done = 1;
                end else begin
                    m_active     = 1;
                    m_reads_left = int'(Length);
                    m_out_left   = int'(Length);
                end
                m_sent = 0;
            end
            m_done_pending = new_done;
        end

        // The FIFO follows whatever the DUT actually popped.
        if (bus.Read && fifo_q.size() != 0) void'(fifo_q.pop_front());

        cyc++;
        @(posedge CLK);
        @(negedge CLK);
        Start = 1'b0;
        Abort = 1'b0;
    endtask

    task automatic start_burst(input int len);
        Start  = 1'b1;
        Length = LW'(len);
        tick();
    endtask

    task automatic run_until_idle(input string tag, input int budget, output int n);
        n = 0;
        while (m_busy() && n < budget) begin
            tick();
            n++;
        end
        if (m_busy()) check({tag, "_timeout"}, m_busy(), 1'b0);
    endtask

    task automatic preload(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(base + DW'(i));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        Rest          = 1'b1;
        Start         = 1'b0;
        Abort         = 1'b0;
        Length        = '0;
        bus.Out_Ready = 1'b0;
        bus.NotEmpty  = 1'b0;
        bus.ReadData  = '0;
        model_reset();
        @(negedge CLK);

        // Reset state
        tick();
        tick();
        Rest = 1'b0;
        check("rst_busy",    Busy,          1'b0);
        check("rst_done",    Done,          1'b0);
        check("rst_valid",   bus.Out_Valid, 1'b0);
        check("rst_last",    bus.Out_Last,  1'b0);
        check("rst_data",    bus.Out_Data,  32'h0);
        check("rst_sentcnt", SentCnt,       16'h0);
        tick();

        // Length=4, preloaded A0..A3, Out_Ready held high: full throughput
        preload(32'hA0, 4);
        ready_mode = 0;
        start_burst(4);
        run_until_idle("t1", 50, n);
        check("t1_cycles",  n,       6);
        check("t1_sentcnt", SentCnt, 16'd4);
        check("t1_busy",    Busy,    1'b0);
        tick();

        // Length=6, FIFO holding 8 words, Out_Ready pattern 1,0,0
        preload(32'h0, 8);
        ready_mode = 1;
        start_burst(6);
        run_until_idle("t2", 200, n);
        check("t2_fifo_left", fifo_q.size(), 2);
        check("t2_sentcnt",   SentCnt,       16'd6);
        fifo_q.delete();
        tick();

        // Length=3 from an empty FIFO fed one word every 3 cycles
        ready_mode = 0;
        feed_mode  = 1;
        feed_word  = 32'h300;
        start_burst(3);
        run_until_idle("t3", 200, n);
        check("t3_sentcnt", SentCnt, 16'd3);
        feed_mode = 0;
        fifo_q.delete();
        tick();

        // Length=0 with data available: Done next cycle, no Read
        preload(32'h400, 2);
        start_burst(0);
        run_until_idle("t4", 20, n);
        check("t4_cycles",  n,             1);
        check("t4_sentcnt", SentCnt,       16'd0);
        check("t4_fifo",    fifo_q.size(), 2);
        fifo_q.delete();
        tick();

        // Length=8, Abort after 3 handshakes with 2 words buffered
        preload(32'h500, 8);
        ready_mode = 0;
        start_burst(8);
        n = 0;
        while (m_sent < 3 && n < 100) begin
            tick();
            n++;
        end
        check("t5_sent3", m_sent, 3);
        ready_mode = 3;
        n = 0;
        while (sb.size() < 2 && n < 100) begin
            tick();
            n++;
        end
        check("t5_buf2", sb.size(), 2);
        Abort = 1'b1;
        tick();
        check("t5_busy",    Busy,          1'b0);
        check("t5_valid",   bus.Out_Valid, 1'b0);
        check("t5_sentcnt", SentCnt,       16'd3);
        tick();
        fifo_q.delete();
        preload(32'h5A0, 2);
        ready_mode = 0;
        start_burst(2);
        run_until_idle("t5b", 50, n);
        check("t5b_sentcnt", SentCnt, 16'd2);
        tick();

        // Start during RUN is ignored; burst completes unchanged
        preload(32'h600, 5);
        ready_mode = 2;
        start_burst(5);
        tick();
        tick();
        Start  = 1'b1;
        Length = LW'(2);
        tick();
        run_until_idle("t6", 200, n);
        check("t6_sentcnt", SentCnt, 16'd5);
        tick();

        // Rest asserted mid-burst: all outputs back to reset values
        preload(32'h700, 6);
        ready_mode = 0;
        start_burst(6);
        tick();
        tick();
        tick();
        Rest = 1'b1;
        tick();
        Rest = 1'b0;
        bus.NotEmpty = (fifo_q.size() != 0);
        #1;
        check("t7_busy",    Busy,          1'b0);
        check("t7_done",    Done,          1'b0);
        check("t7_read",    bus.Read,      1'b0);
        check("t7_valid",   bus.Out_Valid, 1'b0);
        check("t7_last",    bus.Out_Last,  1'b0);
        check("t7_data",    bus.Out_Data,  32'h0);
        check("t7_sentcnt", SentCnt,       16'd0);
        fifo_q.delete();
        tick();

        // Randomized bursts: random lengths, feed, back-pressure and aborts
        feed_mode  = 2;
        ready_mode = 2;
        rand_abort = 1;
        for (int b = 0; b < 20; b++) begin
            start_burst(int'($urandom_range(0, 12)));
            run_until_idle("rand", 2000, n);
            tick();
        end
        rand_abort = 0;
        feed_mode  = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Consumer for the team's synchronous FIFO configured in show-head mode (ShowHead=1).
- On a Start command it pops exactly Length words from the FIFO and presents them on a valid/ready output stream, with Out_Last on the final word.
- A 2-entry skid buffer gives full throughput with no combinational path from Out_Ready to Read.
- Sits between the FIFO and downstream packet or DMA logic.

Parameters:
- DataWidth, 32, width of FIFO words and of Out_Data.
- LenWidth, 16, width of Length and of the internal remaining/sent counters.

Ports:
- CLK  in  1  single clock.
- Rest  in  1  reset: synchronous, active-high.
- Start  in  1  one-cycle command pulse; ignored unless state is IDLE.
- Length  in  LenWidth  burst length in words, sampled on an accepted Start.
- Abort  in  1  synchronous burst cancel.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle pulse at burst completion.
- SentCnt  out  LenWidth  words handshaken on the output in the current or most recent burst.
- NotEmpty  in  1  from FIFO.
- ReadData  in  DataWidth  FIFO head word, valid whenever NotEmpty=1.
- Read  out  1  FIFO pop.
- Out_Data  out  DataWidth  stream data.
- Out_Valid  out  1  stream valid.
- Out_Last  out  1  final word of the burst, qualified by Out_Valid.
- Out_Ready  in  1  downstream accept.

Behaviour:
- Reset (Rest=1 at a CLK edge):
  - State goes to IDLE.
  - Skid buffer count=0, remaining=0, SentCnt=0.
  - Outputs: Busy=0, Done=0, Read=0, Out_Valid=0, Out_Last=0, Out_Data=0.
  - Reset mid-burst discards buffered words. Words already popped are lost; the FIFO is not rewound.
- States: IDLE, RUN, DRAIN, DONE. Encoding is free.
- IDLE:
  - Start with Length!=0: go to RUN, remaining<=Length, SentCnt<=0.
  - Start with Length==0: go to DONE, SentCnt<=0, no FIFO access.
- RUN:
  - Read = NotEmpty & (remaining!=0) & (count!=2). Read is purely registered-state plus NotEmpty; it never depends on Out_Ready.
  - Each Read decrements remaining. The popped ReadData enters the skid buffer at the same edge with last flag = (remaining==1).
  - Read while remaining==1: go to DRAIN.
- DRAIN:
  - Read=0.
  - Go to DONE on the cycle after the handshake of the word whose last flag is set (Out_Valid & Out_Ready & Out_Last).
- DONE:
  - Done=1 for exactly this cycle, Busy=1.
  - Next state is IDLE unconditionally. Start in DONE is ignored.
- Skid buffer:
  - Two entries, each holding data+last; count in 0..2.
  - Out_Valid = (count!=0). Out_Data and Out_Last come from entry 0, the oldest.
  - A handshake pops entry 0.
  - A push and pop in the same cycle leaves count unchanged and preserves order.
  - A push is never issued when count==2.
- Throughput: with NotEmpty=1 and Out_Ready=1 held, steady state is count=1 and one word per cycle.
  - Latency from Start to first Out_Valid is 2 cycles: Start edge, then Read, then valid.
  - Done asserts 1 cycle after the last handshake.
- SentCnt increments on every output handshake and holds its value after the burst until the next accepted Start. Width wraps modulo 2^LenWidth, which is unreachable for a legal Length.
- Abort:
  - In any state other than IDLE: next state is IDLE, buffer is cleared, Read is forced to 0 in that cycle, Done is not pulsed, SentCnt holds.
  - In IDLE: no effect.
  - Start and Abort in the same IDLE cycle: Abort wins and the Start is dropped.
- FIFO empty mid-burst: Read stalls with no timeout and resumes when NotEmpty returns.
- Out_Ready low: the buffer fills to 2, then Read stalls. No word is dropped or duplicated.
- Out_Valid, once high, stays high with Out_Data stable until the handshake, except on Abort or Rest.

Test Plan:
- Reset, then Start with Length=4 and FIFO preloaded with 0xA0..0xA3, Out_Ready=1 -> four Read pulses on consecutive cycles; Out_Data 0xA0,0xA1,0xA2,0xA3 on consecutive cycles; Out_Last only on 0xA3; Done one cycle after; SentCnt=4; Busy falls with Done.
- Length=6, FIFO full, Out_Ready toggling 1,0,0,1,... -> count never exceeds 2; no Read while count==2; output order 0..5 intact; Out_Data stable while Out_Valid & ~Out_Ready.
- Length=3 with FIFO empty, then one word every 3 cycles -> Read fires only when NotEmpty; Out_Last on the 3rd word; Done follows.
- Start with Length=0 -> DONE next cycle, Done pulse, Read never asserted, SentCnt=0.
- Length=8, Abort after 3 handshakes with 2 words buffered -> IDLE next cycle, Out_Valid=0, no Done, SentCnt=3; a following Start with Length=2 runs normally.
- Start during RUN, and Rest asserted mid-burst -> the Start is ignored and the burst completes unchanged; after Rest, all outputs return to reset values on the next edge.
